// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the FSM state enum, the funct3 operation encodings, the iteration
// counter width and a small helper that classifies divide-class ops.
package muldiv_pkg;

  // FSM states of the unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operation encodings carried on funct3.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Iteration counter: 32 steps, counting 0..31.
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  // Divide-class ops all have funct3[2] set.
  function automatic logic is_div_op(logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between a pipeline and muldiv_unit.
// Request side : start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i.
// Response side: busy_o, done_o, rd_wren_o, rd_addr_o, rd_data_o, err_o.
// Suffixes are named from the unit's point of view; the unit uses the
// slave modport and the requester uses the master modport.
interface muldiv_if;

  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;

  logic        busy_o;
  logic        done_o;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        err_o;

  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    output busy_o, done_o, rd_wren_o, rd_addr_o, rd_data_o, err_o
  );

  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    input  busy_o, done_o, rd_wren_o, rd_addr_o, rd_data_o, err_o
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational sign handling for muldiv_unit.
// Ports:
//   funct3_i, rs1_i, rs2_i : op and raw operands presented at start
//   a_mag_o, b_mag_o       : operand magnitudes fed to the unsigned core
//   neg_o                  : whether the final result must be negated
//   raw_i, neg_i           : unsigned core result and latched negate flag
//   fixed_o                : raw_i, two's-complement negated when neg_i
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] a_mag_o,
  output logic [31:0] b_mag_o,
  output logic        neg_o,
  input  logic [63:0] raw_i,
  input  logic        neg_i,
  output logic [63:0] fixed_o
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;

  // Decide which operands are signed, strip their signs, and work out the
  // result sign. Remainders follow the dividend; everything else follows
  // the XOR of the operand signs.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg   = a_signed & rs1_i[31];
    b_neg   = b_signed & rs2_i[31];
    a_mag_o = a_neg ? (~rs1_i + 32'd1) : rs1_i;
    b_mag_o = b_neg ? (~rs2_i + 32'd1) : rs2_i;
    neg_o   = (funct3_i == F3_REM) ? a_neg : (a_neg ^ b_neg);
    fixed_o = neg_i ? (~raw_i + 64'd1) : raw_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit (RV32M style).
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus          : muldiv_if.slave request/response bundle
// Multiplies use a 32-step shift-add on operand magnitudes; divides use a
// 32-step restoring divider. Divide-by-zero and signed overflow complete in
// one cycle without iterating.
// Macro MULDIV_DIV_EN: when defined, divide/remainder ops are implemented.
// When undefined, no divider is built and any funct3[2]=1 op completes in
// one cycle with rd_data_o = 0 and err_o = 1.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic     clk_i,
  input logic     rst_i,
  muldiv_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [31:0]       opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;

  logic [31:0]       a_mag;
  logic [31:0]       b_mag;
  logic              start_neg;
  logic [63:0]       raw_res;
  logic [63:0]       fixed_res;
  logic [31:0]       final_res;

  logic [32:0]       mul_sum;
  logic [63:0]       mul_next;
  logic [63:0]       acc_step;

  logic              fast;
  logic [31:0]       fast_res;
  logic              fast_err;

  muldiv_sign_fix u_sign_fix (
    .funct3_i (bus.funct3_i),
    .rs1_i    (bus.rs1_data_i),
    .rs2_i    (bus.rs2_data_i),
    .a_mag_o  (a_mag),
    .b_mag_o  (b_mag),
    .neg_o    (start_neg),
    .raw_i    (raw_res),
    .neg_i    (neg_q),
    .fixed_o  (fixed_res)
  );

  // Multiply step: acc holds {partial product, remaining multiplier bits}.
  // Add the multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole thing right by one.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  // Restoring divide step: acc holds {remainder, dividend/quotient bits}.
  // Shift the next dividend bit into the remainder, try subtracting the
  // divisor, and keep the difference only if it did not go negative.
  always_comb begin
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
  end

  // Pick the step for the op in flight and present the unsigned result to
  // the sign fixer. Division results sit in the low word so that a 64-bit
  // negate gives the right 32-bit answer.
  always_comb begin
    acc_step = is_div_op(f3_q) ? div_next : mul_next;
    raw_res  = is_div_op(f3_q) ? {32'd0, (f3_q[1] ? acc_step[63:32] : acc_step[31:0])}
                               : acc_step;
  end

  // Divide-by-zero and most-negative / -1 are answered directly.
  always_comb begin
    logic div_zero;
    logic ovf;
    div_zero = (bus.rs2_data_i == 32'd0);
    ovf      = ((bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM)) &&
               (bus.rs1_data_i == 32'h8000_0000) && (bus.rs2_data_i == 32'hFFFF_FFFF);
    fast     = is_div_op(bus.funct3_i) && (div_zero || ovf);
    fast_err = 1'b0;
    if (div_zero) begin
      fast_res = bus.funct3_i[1] ? bus.rs1_data_i : 32'hFFFF_FFFF;
    end else begin
      fast_res = bus.funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end
`else
  // Only multiplies iterate when the divider is left out.
  always_comb begin
    acc_step = mul_next;
    raw_res  = acc_step;
  end

  // Every divide-class op is rejected immediately with an error flag.
  always_comb begin
    fast     = is_div_op(bus.funct3_i);
    fast_res = 32'd0;
    fast_err = 1'b1;
  end
`endif

  // MUL and the divide family return the low word; MULH* the high word.
  always_comb begin
    final_res = ((f3_q == F3_MUL) || is_div_op(f3_q)) ? fixed_res[31:0]
                                                      : fixed_res[63:32];
  end

  // Next-state logic. A start is only taken in IDLE or DONE; starts seen in
  // CALC are dropped. Operands are loaded so that the iterating value sits
  // in the low half of acc and the fixed operand lives in opnd.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    rd_addr_d = rd_addr_q;
    result_d  = result_q;
    err_d     = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          f3_d      = bus.funct3_i;
          rd_addr_d = bus.rd_addr_i;
          neg_d     = start_neg;
          cnt_d     = '0;
          err_d     = 1'b0;
          if (fast) begin
            state_d  = DONE;
            result_d = fast_res;
            err_d    = fast_err;
          end else begin
            state_d = CALC;
            if (is_div_op(bus.funct3_i)) begin
              acc_d  = {32'd0, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {32'd0, b_mag};
              opnd_d = a_mag;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      rd_addr_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      rd_addr_q <= rd_addr_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  // Outputs are decoded from the state; err and the write enable are only
  // ever visible during the single DONE cycle.
  assign bus.busy_o    = (state_q == CALC);
  assign bus.done_o    = (state_q == DONE);
  assign bus.err_o     = bus.done_o & err_q;
  assign bus.rd_wren_o = bus.done_o & ~err_q & (rd_addr_q != 5'd0);
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.rd_data_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// A reference model computes results with plain integer arithmetic and the
// expected completion cycle from the op class; a negedge process compares
// every output against it each cycle, and directed cases pin literal values.
// Honours MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   started = 1'b0;

  // Reference model state for the op in flight.
  bit          opActive = 1'b0;
  bit          opSlow = 1'b0;
  int          opK = 0;
  int          opDoneEdge = 0;
  logic [31:0] opData = '0;
  bit          opErr = 1'b0;
  logic [4:0]  expAddr = '0;
  logic [31:0] expHeld = '0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // 10 ns clock and an edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it and report on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cycle, act, exp);
    end
  endtask

  // Reference result from the arithmetic definition of each op.
  function automatic logic [31:0] refResult(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint     sa, sb, ub, p;
    logic [63:0] up, sp;
    int          ia, ib, iq;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      F3_MUL:    begin p = sa * sb; sp = p; return sp[31:0]; end
      F3_MULH:   begin p = sa * sb; sp = p; return sp[63:32]; end
      F3_MULHSU: begin p = sa * ub; sp = p; return sp[63:32]; end
      F3_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
`ifdef MULDIV_DIV_EN
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        iq = ia / ib;
        return iq;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        iq = ia % ib;
        return iq;
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  // True when the op must iterate for 32 cycles rather than finish at once.
  function automatic bit refSlow(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    if (!f3[2]) return 1'b1;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1'b0;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit refErr(logic [2:0] f3);
`ifdef MULDIV_DIV_EN
    return 1'b0;
`else
    return f3[2];
`endif
  endfunction

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    int  c;
    bit  expBusy, expDone;
    if (started) begin
      c       = cycle;
      expBusy = opActive && opSlow && (c >= opK) && (c <= opK + 31);
      expDone = opActive && (c == opDoneEdge);
      checkOutput("busy", {31'd0, bus.busy_o}, {31'd0, expBusy});
      checkOutput("done", {31'd0, bus.done_o}, {31'd0, expDone});
      checkOutput("rd_addr", {27'd0, bus.rd_addr_o}, {27'd0, expAddr});
      if (expDone) begin
        checkOutput("rd_data", bus.rd_data_o, opData);
        checkOutput("err", {31'd0, bus.err_o}, {31'd0, opErr});
        checkOutput("rd_wren", {31'd0, bus.rd_wren_o}, {31'd0, (expAddr != 0) && !opErr});
        expHeld = opData;
      end else begin
        checkOutput("err_idle", {31'd0, bus.err_o}, 32'd0);
        checkOutput("wren_idle", {31'd0, bus.rd_wren_o}, 32'd0);
        if (!opActive || c > opDoneEdge)
          checkOutput("rd_data_held", bus.rd_data_o, expHeld);
      end
    end
  end

  // Present one start request for a single edge and update the model with
  // whether the unit should accept it. Operands are scrambled afterwards.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    int k;
    bit inCalc;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.funct3_i   = f3;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    @(posedge clk);
    #1;
    k      = cycle;
    inCalc = opActive && opSlow && (k - 1 >= opK) && (k - 1 <= opK + 31);
    if (!inCalc) begin
      opActive   = 1'b1;
      opK        = k;
      opSlow     = refSlow(f3, a, b);
      opDoneEdge = opSlow ? k + 32 : k;
      opData     = refResult(f3, a, b);
      opErr      = refErr(f3);
      expAddr    = rd;
    end
    bus.start_i    = 1'b0;
    bus.funct3_i   = 3'($urandom_range(0, 7));
    bus.rs1_data_i = $urandom;
    bus.rs2_data_i = $urandom;
    bus.rd_addr_i  = 5'($urandom_range(0, 31));
  endtask

  // Reset for one edge, optionally with a coincident start request.
  task automatic applyReset(input bit withStart);
    @(negedge clk);
    rst            = 1'b1;
    bus.start_i    = withStart;
    bus.funct3_i   = F3_MUL;
    bus.rs1_data_i = 32'd3;
    bus.rs2_data_i = 32'd3;
    bus.rd_addr_i  = 5'd9;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.start_i = 1'b0;
    opActive    = 1'b0;
    expHeld     = '0;
    expAddr     = '0;
    started     = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done_o, sampling just after each rising edge.
  task automatic waitForDone(input int budget);
    for (int i = 0; i <= budget; i++) begin
      if (bus.done_o) return;
      @(posedge clk);
      #1;
    end
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL wait_done: no done_o within %0d cycles", budget);
  endtask

  // Directed case: run one op to completion and pin data and latency.
  task automatic runCase(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] expData, input int expLat);
    int kStart;
    applyStimulus(f3, a, b, rd);
    kStart = cycle;
    waitForDone(40);
    checkOutput(name, bus.rd_data_o, expData);
    checkOutput({name, "_lat"}, cycle - kStart, expLat);
  endtask

  initial begin
    int k1;
    bus.start_i    = 1'b0;
    bus.funct3_i   = '0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    bus.rd_addr_i  = '0;
    repeat (2) @(posedge clk);

    applyReset(1'b0);
    checkOutput("rst_data", bus.rd_data_o, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy_o}, 32'd0);

    // Multiplies, including signed/unsigned high words and a zero operand.
    runCase("mul_7x-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 32);
    checkOutput("mul_wren", {31'd0, bus.rd_wren_o}, 32'd1);
    checkOutput("mul_addr", {27'd0, bus.rd_addr_o}, 32'd5);
    waitCycles(1);
    runCase("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 32);
    runCase("mulh_m1", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 32);
    runCase("mulhsu_m1", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 32);
    runCase("mulh_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 32);
    runCase("mul_zero", F3_MUL, 32'd0, 32'd12345, 5'd6, 32'd0, 32);
    waitCycles(2);

`ifdef MULDIV_DIV_EN
    runCase("div_-7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 32);
    runCase("rem_-7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 32);
    runCase("divu_100/7", F3_DIVU, 32'd100, 32'd7, 5'd8, 32'd14, 32);
    runCase("remu_100/7", F3_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 32);
    runCase("divu_5/0", F3_DIVU, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
    waitCycles(1);
    runCase("rem_5/0", F3_REM, 32'd5, 32'd0, 5'd9, 32'd5, 0);
    waitCycles(1);
    runCase("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0);
    waitCycles(1);
    runCase("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 0);
    waitCycles(1);
`else
    runCase("div_noen", F3_DIV, 32'd5, 32'd1, 5'd7, 32'd0, 0);
    checkOutput("div_noen_err", {31'd0, bus.err_o}, 32'd1);
    checkOutput("div_noen_wren", {31'd0, bus.rd_wren_o}, 32'd0);
    waitCycles(1);
`endif

    // Destination x0: completes, but no register write.
    runCase("mul_rd0", F3_MUL, 32'd9, 32'd9, 5'd0, 32'd81, 32);
    checkOutput("rd0_wren", {31'd0, bus.rd_wren_o}, 32'd0);

    // Back-to-back: start taken while in DONE.
    runCase("b2b_first", F3_MUL, 32'd3, 32'd4, 5'd2, 32'd12, 32);
    k1 = cycle;
    runCase("b2b_second", F3_MUL, 32'd5, 32'd6, 5'd3, 32'd30, 32);
    checkOutput("b2b_gap", cycle - k1, 33);
    waitCycles(2);

    // A start during CALC is dropped and does not disturb the op in flight.
    applyStimulus(F3_MUL, 32'd6, 32'd7, 5'd4);
    waitCycles(5);
    applyStimulus(F3_MUL, 32'd2, 32'd2, 5'd11);
    waitForDone(40);
    checkOutput("ignored_start_data", bus.rd_data_o, 32'd42);
    checkOutput("ignored_start_addr", {27'd0, bus.rd_addr_o}, 32'd4);
    waitCycles(2);

    // Long op, a dropped start, then reset mid-flight: no done ever follows.
`ifdef MULDIV_DIV_EN
    applyStimulus(F3_DIVU, 32'd1000, 32'd7, 5'd12);
`else
    applyStimulus(F3_MULHU, 32'd1000, 32'd7, 5'd12);
`endif
    waitCycles(9);
    applyStimulus(F3_MUL, 32'd9, 32'd9, 5'd13);
    waitCycles(9);
    applyReset(1'b0);
    checkOutput("abort_data", bus.rd_data_o, 32'd0);
    checkOutput("abort_addr", {27'd0, bus.rd_addr_o}, 32'd0);
    checkOutput("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    waitCycles(40);

    // Reset wins over a coincident start.
    applyReset(1'b1);
    checkOutput("rst_prio_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("rst_prio_done", {31'd0, bus.done_o}, 32'd0);
    waitCycles(36);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 start_i  in  1  request; sampled on a clock edge while state is IDLE or DONE.
REQ-005 funct3_i  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data_i  in  32  operand A, from register-file read port 1.
REQ-007 rs2_data_i  in  32  operand B, from register-file read port 2.
REQ-008 rd_addr_i  in  5  destination register index.
REQ-009 busy_o  out  1  high while state is CALC.
REQ-010 done_o  out  1  one-cycle pulse when the result is valid.
REQ-011 rd_wren_o  out  1  register-file write enable: done_o AND (rd_addr_o != 0).
REQ-012 rd_addr_o  out  5  destination index latched at start.
REQ-013 rd_data_o  out  32  result; held until the next accepted start.
REQ-014 err_o  out  1  pulses with done_o when an op is unsupported (see REQ-030).

Function
REQ-015 FSM states: IDLE, CALC, DONE. IDLE->CALC on start; CALC->DONE when the iteration counter reaches 31; DONE->IDLE with no start, or DONE->CALC on start.
REQ-016 start_i is ignored while in CALC, with no effect on operands or counter.
REQ-017 At start, latch funct3_i, rs1_data_i, rs2_data_i and rd_addr_i; later input changes do not affect the op in flight.
REQ-018 Start sampled at edge k: busy_o is high for cycles k+1..k+32, and done_o is high only in cycle k+33.
REQ-019 Multiply: 32-step shift-add on operand magnitudes into a 64-bit product.
  - MUL: low 32 bits.
  - MULH: high 32 bits, signed x signed.
  - MULHSU: high 32 bits, signed x unsigned.
  - MULHU: high 32 bits, unsigned x unsigned.
REQ-020 Signed ops take absolute values before iterating and negate the result if the sign rule requires it.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
REQ-021 Divide: 32-step restoring division producing a 32-bit quotient and a 32-bit remainder.
REQ-022 Divide by zero (rs2 = 0, DIV/DIVU/REM/REMU) uses a fast path: skip CALC, go IDLE->DONE, done_o in cycle k+1.
  - Quotient = 0xFFFFFFFF.
  - Remainder = A.
REQ-023 Signed overflow (DIV/REM with A = 0x80000000, B = 0xFFFFFFFF) uses a fast path with done_o in cycle k+1.
  - Quotient = 0x80000000.
  - Remainder = 0.
REQ-024 A start accepted in DONE begins a new op the next cycle; done_o for the prior op still pulses exactly once.
REQ-025 rd_addr = 0: the op completes normally and done_o pulses, but rd_wren_o stays low.
REQ-026 Multiplication has no fast paths; an operand of 0 still takes 33 cycles.

Reset
REQ-027 With rst_i high at an edge: state = IDLE, counter = 0, done_o = 0, rd_wren_o = 0, busy_o = 0, err_o = 0, rd_addr_o = 0, rd_data_o = 0.
REQ-028 Reset during CALC abandons the op; no done_o is produced for it.
REQ-029 rst_i has priority over a coincident start_i.

Configuration
REQ-030 Macro MULDIV_DIV_EN.
  - Defined: division and remainder ops supported as above.
  - Undefined: funct3_i[2] = 1 takes the fast path; done_o at k+1, rd_data_o = 0, err_o = 1, rd_wren_o = 0, no divider logic synthesized.

Structure
REQ-031 Package muldiv_pkg holds:
  - the state enum (IDLE/CALC/DONE);
  - the funct3 localparams (F3_MUL..F3_REMU);
  - the counter width constant (5).
REQ-032 One combinational sub-module, muldiv_sign_fix, handles operand absolute value and result negation; the FSM and datapath stay in muldiv_unit.

Verification
REQ-033 MUL 7 x -3, rd = 5 -> done_o at k+33, rd_data_o = 0xFFFFFFEB, rd_wren_o = 1, rd_addr_o = 5.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; each completes at k+33.
REQ-036 Fast paths:
  - DIVU 5 / 0 -> 0xFFFFFFFF at k+1.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / -1 -> 0x80000000, at k+1.
REQ-037 Start DIVU, pulse start_i at k+10 with new operands, then assert rst_i at k+20 -> second start ignored; no done_o; outputs are the reset values at k+21.
REQ-038 Start MUL rd = 0 -> done_o pulses and rd_wren_o stays 0.
  - Back-to-back start in DONE -> second done_o at +33.
  - Without MULDIV_DIV_EN: DIV -> err_o = 1 at k+1.
